// File: rtl/adc_rx_pkg.sv
// Shared types and width helpers for the serial ADC frame receiver.
package adc_rx_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_e;

  function automatic int frame_w(input int lead_w, input int data_w);
    return lead_w + data_w;
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of a down-counter holding 0..v-1, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (clog2_f(v) < 1) ? 1 : clog2_f(v);
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// First-word fall-through sample FIFO; a push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module adc_sample_fifo
  import adc_rx_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             drop
);

  localparam int PTR_W = clog2_f(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, pop, wr_en;

  assign rd_valid = (cnt_q != '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  // When full, the slot being written is the head being popped this same cycle.
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adc_serial_frame_rx.sv
// Serial ADC frame receiver: drives CS and the sampling clock, captures NUM_CH lines into a FIFO.
// Build option ADC_LEAD_CHECK_EN adds a sticky lead_err flag for non-zero lead bits.
//
//   state | meaning
//   IDLE  | CS high, waiting for start
//   SETUP | CS low, serial clock high for CLK_DIV cycles
//   SHIFT | FRAME_W bits, each CLK_DIV low then CLK_DIV high; sample on the rise
//   QUIET | CS high for QUIET_CYC cycles between frames
module adc_serial_frame_rx
  import adc_rx_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LEAD_W     = 4,
  parameter int NUM_CH     = 2,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clock_In,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        data_ADC,
  input  logic                     sample_ready,
  input  logic                     clr_ovf,
  output logic                     CS,
  output logic                     Clock_Muestreo,
  output logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  output logic                     done,
  output logic                     busy,
  output logic                     overflow
`ifdef ADC_LEAD_CHECK_EN
  , output logic                   lead_err
`endif
);

  localparam int FRAME_W = frame_w(LEAD_W, DATA_W);
  localparam int BIT_W   = cnt_w(FRAME_W);
  localparam int DIV_W   = cnt_w((CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC);

  state_e                         state_q, state_d;
  logic [DIV_W-1:0]               div_q, div_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic                           cs_q, cs_d, sclk_q, sclk_d;
  logic                           done_q, done_d, busy_q, busy_d;
  logic                           overflow_q, overflow_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  shreg_q, shreg_d;
  logic                           push, drop;
`ifdef ADC_LEAD_CHECK_EN
  logic                           lead_err_q, lead_err_d, lead_hit;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    push    = 1'b0;
`ifdef ADC_LEAD_CHECK_EN
    lead_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          div_d   = DIV_W'(CLK_DIV - 1);
        end
      end
      SETUP: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          div_d   = DIV_W'(CLK_DIV - 1);
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_W'(CLK_DIV - 1);
          if (bit_q >= BIT_W'(LEAD_W)) begin
            for (int c = 0; c < NUM_CH; c++)
              shreg_d[c] = {shreg_q[c][DATA_W-2:0], data_ADC[c]};
          end else begin
`ifdef ADC_LEAD_CHECK_EN
            lead_hit = |data_ADC;
`endif
          end
        end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
          // The last high half-period has elapsed: close the frame.
          state_d = QUIET;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          push    = 1'b1;
          div_d   = DIV_W'(QUIET_CYC - 1);
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q + 1'b1;
          div_d  = DIV_W'(CLK_DIV - 1);
        end
      end
      QUIET: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          div_d   = DIV_W'(CLK_DIV - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
`ifdef ADC_LEAD_CHECK_EN
    lead_err_d = lead_hit ? 1'b1 : (clr_ovf ? 1'b0 : lead_err_q);
`endif
  end

  always_ff @(posedge clock_In) begin
    if (!Reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      shreg_q    <= '0;
`ifdef ADC_LEAD_CHECK_EN
      lead_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      shreg_q    <= shreg_d;
`ifdef ADC_LEAD_CHECK_EN
      lead_err_q <= lead_err_d;
`endif
    end
  end

  adc_sample_fifo #(
    .WIDTH (NUM_CH * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (clock_In),
    .rst_b     (Reset),
    .push      (push),
    .push_data (shreg_q),
    .rd_ready  (sample_ready),
    .rd_data   (sample_data),
    .rd_valid  (sample_valid),
    .drop      (drop)
  );

  assign CS             = cs_q;
  assign Clock_Muestreo = sclk_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;
`ifdef ADC_LEAD_CHECK_EN
  assign lead_err       = lead_err_q;
`endif

endmodule

// File: tb/tb_adc_serial_frame_rx.sv
// Directed bench for adc_serial_frame_rx with a behavioural two-channel ADC model.
module tb_adc_serial_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n, start, sample_ready, clr_ovf;
  logic [1:0]  data_adc = 2'b00;
  logic        cs, sclk, valid, done, busy, overflow;
  logic [23:0] sample_data;
`ifdef ADC_LEAD_CHECK_EN
  logic        lead_err;
`endif

  always #5 clk = ~clk;

  adc_serial_frame_rx dut (
    .clock_In       (clk),
    .Reset          (rst_n),
    .start          (start),
    .data_ADC       (data_adc),
    .sample_ready   (sample_ready),
    .clr_ovf        (clr_ovf),
    .CS             (cs),
    .Clock_Muestreo (sclk),
    .sample_data    (sample_data),
    .sample_valid   (valid),
    .done           (done),
    .busy           (busy),
    .overflow       (overflow)
`ifdef ADC_LEAD_CHECK_EN
    , .lead_err     (lead_err)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC model: per-frame words from a table, 4 lead bits then 12 data bits, MSB first,
  // each bit driven on the falling edge of the serial clock.
  logic [11:0] t0 [16];
  logic [11:0] t1 [16];
  logic [3:0]  l1 [16];
  int          fidx = 0;
  int          bidx = 0;
  logic [15:0] f0, f1;

  always @(negedge cs) begin
    if (fidx < 16) begin
      f0 = {4'h0, t0[fidx]};
      f1 = {l1[fidx], t1[fidx]};
    end
    fidx++;
    bidx = 0;
  end

  always @(negedge sclk) begin
    if (!cs && bidx < 16) begin
      data_adc[0] = f0[15-bidx];
      data_adc[1] = f1[15-bidx];
      bidx++;
    end
  end

  task automatic wait_cs_fall();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cs === 1'b0) return;
    end
    check("cs_fall_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic pop_word(input string tag, input logic [23:0] exp);
    check({tag, "_valid"}, {31'd0, valid}, 1);
    check(tag, {8'd0, sample_data}, {8'd0, exp});
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_low;
    int extra_cs;
    for (int i = 0; i < 16; i++) begin
      t0[i] = 12'h000;
      t1[i] = 12'h000;
      l1[i] = 4'h0;
    end
    t0[0]  = 12'hA5C; t1[0]  = 12'h3F1;
    t0[1]  = 12'h111; t1[1]  = 12'h222;
    t0[2]  = 12'h333; t1[2]  = 12'h444;
    t0[3]  = 12'h555; t1[3]  = 12'h666;
    t0[4]  = 12'h777; t1[4]  = 12'h888;
    t0[5]  = 12'h999; t1[5]  = 12'hAAA;
    t0[6]  = 12'hBCD; t1[6]  = 12'h123;
    t0[7]  = 12'h0F0; t1[7]  = 12'h00F;
    t0[8]  = 12'hFFF; t1[8]  = 12'hFFF;
    t0[9]  = 12'h456; t1[9]  = 12'h789;
    t0[10] = 12'h5A5; t1[10] = 12'hC3C; l1[10] = 4'b0010;

    rst_n = 1'b0; start = 1'b0; sample_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, cs}, 1);
    check("rst_sclk", {31'd0, sclk}, 1);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
`ifdef ADC_LEAD_CHECK_EN
    check("rst_lead_err", {31'd0, lead_err}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // single frame; start dropped right after CS falls
    start = 1'b1;
    @(negedge clk);
    check("t1_cs_fall", {31'd0, cs}, 0);
    check("t1_busy", {31'd0, busy}, 1);
    start = 1'b0;
    cs_low = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cs) break;
      cs_low++;
    end
    check("t1_cs_low_cycles", cs_low, 132);
    check("t1_done", {31'd0, done}, 1);
    check("t1_valid", {31'd0, valid}, 1);
    check("t1_data", {8'd0, sample_data}, 32'h003F1A5C);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 0);
    check("t1_busy_quiet", {31'd0, busy}, 1);
    @(negedge clk);
    check("t1_busy_idle", {31'd0, busy}, 0);
    extra_cs = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (!cs) extra_cs++;
    end
    check("t5_no_second_cs", extra_cs, 0);
    pop_word("t1_pop", 24'h3F1A5C);
    check("t1_empty", {31'd0, valid}, 0);

    // five back-to-back frames, no consumer: fifth is dropped
    start = 1'b1;
    for (int f = 0; f < 5; f++) wait_done();
    start = 1'b0;
    wait_idle();
    check("t2_ovf", {31'd0, overflow}, 1);
    check("t2_head", {8'd0, sample_data}, 32'h00222111);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t2_ovf_clr", {31'd0, overflow}, 0);

    // push into full FIFO with a pop in the same cycle
    start = 1'b1;
    wait_cs_fall();
    start = 1'b0;
    repeat (131) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("t3_done", {31'd0, done}, 1);
    check("t3_no_ovf", {31'd0, overflow}, 0);
    check("t3_head_adv", {8'd0, sample_data}, 32'h00444333);
    wait_idle();
    pop_word("t3_w2", 24'h444333);
    pop_word("t3_w3", 24'h666555);
    pop_word("t3_w4", 24'h888777);
    pop_word("t3_w6", 24'h123BCD);
    check("t3_empty", {31'd0, valid}, 0);

    // reset in the middle of a frame
    start = 1'b1;
    wait_done();
    check("t4_prev_valid", {31'd0, valid}, 1);
    check("t4_prev_data", {8'd0, sample_data}, 32'h0000F0F0);
    wait_cs_fall();
    repeat (62) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t4_cs", {31'd0, cs}, 1);
    check("t4_sclk", {31'd0, sclk}, 1);
    check("t4_valid", {31'd0, valid}, 0);
    check("t4_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    wait_cs_fall();
    start = 1'b0;
    wait_done();
    wait_idle();
    pop_word("t4_clean", 24'h789456);
    check("t4_no_partial", {31'd0, valid}, 0);

    // lead bit 2 set on ch1
`ifdef ADC_LEAD_CHECK_EN
    check("t6_lead_err_pre", {31'd0, lead_err}, 0);
`endif
    start = 1'b1;
    wait_cs_fall();
    start = 1'b0;
    wait_done();
    check("t6_data", {8'd0, sample_data}, 32'h00C3C5A5);
`ifdef ADC_LEAD_CHECK_EN
    check("t6_lead_err", {31'd0, lead_err}, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t6_lead_err_clr", {31'd0, lead_err}, 0);
`endif
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
